// File: rtl/rv32_fu_pkg.sv
// Shared functional-unit constants for the RV32 issue logic.
package rv32_fu_pkg;

    localparam int NUM_FU         = 6;
    localparam int MAX_FU_LATENCY = 31;
    localparam int FU_ID_W        = 3;
    localparam int LAT_W          = 5;
    localparam int REG_W          = 5;

    localparam logic [FU_ID_W-1:0] FU_ALU  = 3'd0;
    localparam logic [FU_ID_W-1:0] FU_MEM  = 3'd1;
    localparam logic [FU_ID_W-1:0] FU_MUL  = 3'd2;
    localparam logic [FU_ID_W-1:0] FU_DIV  = 3'd3;
    localparam logic [FU_ID_W-1:0] FU_FPU  = 3'd4;
    localparam logic [FU_ID_W-1:0] FU_JUMP = 3'd5;

    // Reservation entries store FU ID + 1 so that zero can mean "slot empty".
    function automatic logic [FU_ID_W-1:0] fu_tag(input logic [FU_ID_W-1:0] fu);
        return fu + FU_ID_W'(1);
    endfunction

endpackage

// File: rtl/fu_reservation_shifter.sv
// Writeback reservation table: slot k names the FU writing back k cycles from now.
module fu_reservation_shifter
    import rv32_fu_pkg::*;
#(
    parameter int DEPTH   = MAX_FU_LATENCY + 1,
    parameter int IDX_W   = LAT_W,
    parameter int ENTRY_W = FU_ID_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [ENTRY_W-1:0] wr_val,
    input  logic [IDX_W-1:0]   look_idx,
    output logic [ENTRY_W-1:0] slot0,
    output logic [ENTRY_W-1:0] look_val
);

    logic [ENTRY_W-1:0] reservation_reg [DEPTH];

    // Advance the table one slot per cycle; a new reservation lands in the post-shift table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) reservation_reg[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) reservation_reg[k] <= '0;
        end else begin
            if (shift) begin
                for (int k = 0; k < DEPTH - 1; k++) reservation_reg[k] <= reservation_reg[k+1];
                reservation_reg[DEPTH-1] <= '0;
            end
            if (wr_en && (int'(wr_idx) < DEPTH)) reservation_reg[wr_idx] <= wr_val;
        end
    end

    // Slot 0 drives writeback; the lookup slot detects writeback-port collisions.
    always_comb begin
        slot0    = reservation_reg[0];
        look_val = '0;
        if (int'(look_idx) < DEPTH) look_val = reservation_reg[look_idx];
    end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Scoreboard-style issue scheduler: tracks busy FUs, pending destinations and
// the shared writeback port, and only accepts hazard-free instructions.
module fu_issue_scheduler #(
    parameter int NUM_FU         = rv32_fu_pkg::NUM_FU,
    parameter int MAX_FU_LATENCY = rv32_fu_pkg::MAX_FU_LATENCY
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  issue_valid,
    input  logic [rv32_fu_pkg::FU_ID_W-1:0]       issue_fu,
    input  logic [rv32_fu_pkg::LAT_W-1:0]         issue_lat,
    input  logic [rv32_fu_pkg::REG_W-1:0]         issue_rd,
    input  logic [rv32_fu_pkg::REG_W-1:0]         issue_rs1,
    input  logic [rv32_fu_pkg::REG_W-1:0]         issue_rs2,
    output logic                                  issue_ready,
    input  logic                                  flush,
    output logic [NUM_FU-1:0]                     fu_status,
    output logic [NUM_FU*rv32_fu_pkg::REG_W-1:0]  fu_write_to,
    output logic [NUM_FU-1:0]                     fu_writeback_en,
    output logic [rv32_fu_pkg::REG_W-1:0]         wb_rd,
    output logic                                  err_lat
);

    import rv32_fu_pkg::*;

    localparam int DEPTH = MAX_FU_LATENCY + 1;

    logic [NUM_FU-1:0]  FU_status;
    logic [REG_W-1:0]   FU_write_to [NUM_FU];
    logic [NUM_FU-1:0]  FU_writeback_en;

    logic [FU_ID_W-1:0] slot0;
    logic [FU_ID_W-1:0] look_val;
    logic               legal;
    logic               busy_hit;
    logic               raw_hit;
    logic               waw_hit;
    logic               port_hit;
    logic               accept;
    logic [NUM_FU-1:0]  accept_mask;
    logic [REG_W-1:0]   wb_sel;

    fu_reservation_shifter #(
        .DEPTH   (DEPTH),
        .IDX_W   (LAT_W),
        .ENTRY_W (FU_ID_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .shift    (1'b1),
        .clear    (flush),
        .wr_en    (accept),
        .wr_idx   (issue_lat - LAT_W'(1)),
        .wr_val   (fu_tag(issue_fu)),
        .look_idx (issue_lat),
        .slot0    (slot0),
        .look_val (look_val)
    );

    // Hazard detection against every busy FU; there is no bypass, so an FU in its
    // own writeback cycle still blocks dependants.
    always_comb begin
        legal    = (issue_lat != '0) && (int'(issue_lat) <= MAX_FU_LATENCY) &&
                   (int'(issue_fu) < NUM_FU);
        busy_hit = 1'b0;
        raw_hit  = 1'b0;
        waw_hit  = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (FU_status[f]) begin
                if (int'(issue_fu) == f) busy_hit = 1'b1;
                if ((issue_rs1 != '0 && issue_rs1 == FU_write_to[f]) ||
                    (issue_rs2 != '0 && issue_rs2 == FU_write_to[f])) raw_hit = 1'b1;
                if (issue_rd != '0 && issue_rd == FU_write_to[f]) waw_hit = 1'b1;
            end
        end
        port_hit    = (look_val != '0);
        issue_ready = legal & ~busy_hit & ~raw_hit & ~waw_hit & ~port_hit & ~flush;
        accept      = issue_valid & issue_ready;
        accept_mask = '0;
        for (int f = 0; f < NUM_FU; f++)
            if (accept && int'(issue_fu) == f) accept_mask[f] = 1'b1;
    end

    // Decode slot 0 into the one-hot writeback strobe and the register written back.
    always_comb begin
        FU_writeback_en = '0;
        wb_sel          = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (int'(slot0) == f + 1) begin
                FU_writeback_en[f] = 1'b1;
                wb_sel             = FU_write_to[f];
            end
        end
    end

    // Per-FU busy flag and destination: set on accept, busy cleared after writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FU_status <= '0;
            for (int f = 0; f < NUM_FU; f++) FU_write_to[f] <= '0;
        end else if (flush) begin
            FU_status <= '0;
            for (int f = 0; f < NUM_FU; f++) FU_write_to[f] <= '0;
        end else begin
            FU_status <= (FU_status & ~FU_writeback_en) | accept_mask;
            for (int f = 0; f < NUM_FU; f++)
                if (accept_mask[f]) FU_write_to[f] <= issue_rd;
        end
    end

    // Sticky flag for an instruction presented with an illegal latency or FU ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       err_lat <= 1'b0;
        else if (issue_valid && !legal) err_lat <= 1'b1;
    end

    // Flatten the per-FU destinations onto the output bus.
    always_comb begin
        fu_write_to = '0;
        for (int f = 0; f < NUM_FU; f++) fu_write_to[f*REG_W +: REG_W] = FU_write_to[f];
    end

    assign fu_status       = FU_status;
    assign fu_writeback_en = FU_writeback_en;
    assign wb_rd           = wb_sel;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Bench for fu_issue_scheduler: directed scenarios with literal expectations plus a
// per-cycle comparison against a list-of-pending-instructions model.
module tb_fu_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  issue_fu;
    logic [4:0]  issue_lat;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_ready;
    logic        flush;
    logic [5:0]  fu_status;
    logic [29:0] fu_write_to;
    logic [5:0]  fu_writeback_en;
    logic [4:0]  wb_rd;
    logic        err_lat;

    int n_cmp = 0;
    int n_bad = 0;

    fu_issue_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_fu        (issue_fu),
        .issue_lat       (issue_lat),
        .issue_rd        (issue_rd),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_ready     (issue_ready),
        .flush           (flush),
        .fu_status       (fu_status),
        .fu_write_to     (fu_write_to),
        .fu_writeback_en (fu_writeback_en),
        .wb_rd           (wb_rd),
        .err_lat         (err_lat)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int fu;
        int rd;
        int wb;   // absolute cycle in which this instruction writes back
    } op_t;

    op_t         pend[$];
    int          mwt[6];
    bit          merr = 1'b0;
    int          cyc = 0;
    logic [5:0]  e_en, e_st;
    logic [29:0] e_wt;
    int          e_rd, m_fu, m_lat;
    bit          legal, rdy;
    op_t         nop;

    // Compare every cycle at the falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            for (int i = 0; i < 6; i++) mwt[i] = 0;
            merr = 1'b0;
        end else begin
            e_en = '0; e_st = '0; e_rd = 0; e_wt = '0;
            m_fu = int'(issue_fu); m_lat = int'(issue_lat);
            foreach (pend[i]) begin
                e_st[pend[i].fu] = 1'b1;
                if (pend[i].wb == cyc) begin
                    e_en[pend[i].fu] = 1'b1;
                    e_rd = pend[i].rd;
                end
            end
            for (int i = 0; i < 6; i++) e_wt[i*5 +: 5] = 5'(mwt[i]);
            legal = (m_lat >= 1) && (m_lat <= 31) && (m_fu < 6);
            rdy   = legal && !flush;
            foreach (pend[i]) begin
                if (pend[i].fu == m_fu) rdy = 1'b0;
                if (pend[i].wb == cyc + m_lat) rdy = 1'b0;
                if (pend[i].rd != 0 && (pend[i].rd == int'(issue_rs1) ||
                    pend[i].rd == int'(issue_rs2) || pend[i].rd == int'(issue_rd))) rdy = 1'b0;
            end
            check("m_ready",     32'(issue_ready),     32'(rdy));
            check("m_wb_en",     32'(fu_writeback_en), 32'(e_en));
            check("m_wb_rd",     32'(wb_rd),           32'(e_rd));
            check("m_fu_status", 32'(fu_status),       32'(e_st));
            check("m_write_to",  32'(fu_write_to),     32'(e_wt));
            check("m_err_lat",   32'(err_lat),         32'(merr));
            if (flush) begin
                pend.delete();
                for (int i = 0; i < 6; i++) mwt[i] = 0;
            end else begin
                for (int i = pend.size() - 1; i >= 0; i--)
                    if (pend[i].wb <= cyc) pend.delete(i);
                if (issue_valid && rdy) begin
                    nop.fu = m_fu; nop.rd = int'(issue_rd); nop.wb = cyc + m_lat;
                    pend.push_back(nop);
                    mwt[m_fu] = int'(issue_rd);
                end
            end
            if (issue_valid && !legal) merr = 1'b1;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int fu, input int lat, input int rd,
                         input int rs1, input int rs2);
        issue_valid = v;
        issue_fu    = 3'(fu);
        issue_lat   = 5'(lat);
        issue_rd    = 5'(rd);
        issue_rs1   = 5'(rs1);
        issue_rs2   = 5'(rs2);
    endtask

    task automatic idle();
        drive(1'b0, 0, 1, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_three();
        drive(1'b1, 0, 8, 1, 0, 0); step();
        drive(1'b1, 1, 6, 2, 0, 0); step();
        drive(1'b1, 2, 4, 3, 0, 0); step();
        idle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; idle();
        #3;
        check("rst_status",   32'(fu_status),       32'd0);
        check("rst_wb_en",    32'(fu_writeback_en), 32'd0);
        check("rst_wb_rd",    32'(wb_rd),           32'd0);
        check("rst_err",      32'(err_lat),         32'd0);
        check("rst_write_to", 32'(fu_write_to),     32'd0);
        step(); step(); rst = 1'b0;

        // single issue: fu2 L=4 rd=5
        drive(1'b1, 2, 4, 5, 0, 0); #1 check("single_ready", 32'(issue_ready), 32'd1);
        step(); idle(); step(); step(); step();
        #1;
        check("single_wb_en",  32'(fu_writeback_en), 32'b000100);
        check("single_wb_rd",  32'(wb_rd),           32'd5);
        check("single_busy",   32'(fu_status[2]),    32'd1);
        step(); #1 check("single_retired", 32'(fu_status), 32'd0);

        // writeback port conflict
        step(); drive(1'b1, 1, 3, 10, 0, 0); #1 check("port_first", 32'(issue_ready), 32'd1);
        step(); drive(1'b1, 3, 2, 11, 0, 0); #1 check("port_stall", 32'(issue_ready), 32'd0);
        step(); #1 check("port_accept", 32'(issue_ready), 32'd1);
        step(); idle(); repeat (4) step();

        // RAW on rd=7
        drive(1'b1, 0, 5, 7, 0, 0); #1 check("raw_first", 32'(issue_ready), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step(); drive(1'b1, 1, 1, 0, 7, 0); #1 check("raw_stall", 32'(issue_ready), 32'd0);
        end
        step(); #1 check("raw_release", 32'(issue_ready), 32'd1);
        step(); idle(); repeat (3) step();

        // WAW on rd=9 and busy fu4
        drive(1'b1, 4, 6, 9, 0, 0); #1 check("waw_first", 32'(issue_ready), 32'd1);
        step(); drive(1'b1, 5, 2, 9, 0, 0); #1 check("waw_stall", 32'(issue_ready), 32'd0);
        for (int k = 2; k <= 6; k++) begin
            step(); drive(1'b1, 4, 2, 9, 0, 0); #1 check("busy_stall", 32'(issue_ready), 32'd0);
        end
        step(); #1 check("busy_release", 32'(issue_ready), 32'd1);
        step(); idle(); repeat (4) step();

        // illegal latency / FU ID
        drive(1'b1, 0, 0, 3, 0, 0); #1 check("lat0_ready", 32'(issue_ready), 32'd0);
        step(); idle(); #1 check("lat0_err", 32'(err_lat), 32'd1);
        repeat (3) step();
        #1 check("err_sticky", 32'(err_lat), 32'd1);
        drive(1'b1, 6, 3, 0, 0, 0); #1 check("badfu_ready", 32'(issue_ready), 32'd0);
        step(); idle();

        // reset mid-flight
        step(); issue_three();
        step(); #1 check("pre_rst_busy", 32'(fu_status), 32'b000111);
        #1 rst = 1'b1;
        #1;
        check("arst_status",   32'(fu_status),       32'd0);
        check("arst_wb_en",    32'(fu_writeback_en), 32'd0);
        check("arst_wb_rd",    32'(wb_rd),           32'd0);
        check("arst_err",      32'(err_lat),         32'd0);
        check("arst_write_to", 32'(fu_write_to),     32'd0);
        step(); step(); rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1 check("post_rst_quiet", 32'(fu_writeback_en), 32'd0);
            step();
        end

        // flush mid-flight, coinciding with fu2's writeback
        issue_three();
        step(); step(); step();
        drive(1'b1, 3, 2, 20, 0, 0); flush = 1'b1;
        #1;
        check("flush_ready", 32'(issue_ready),     32'd0);
        check("flush_wb_en", 32'(fu_writeback_en), 32'b000100);
        check("flush_wb_rd", 32'(wb_rd),           32'd3);
        step(); flush = 1'b0; idle();
        #1;
        check("flush_status",   32'(fu_status),   32'd0);
        check("flush_write_to", 32'(fu_write_to), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(); #1 check("post_flush_quiet", 32'(fu_writeback_en), 32'd0);
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fu_issue_scheduler.md
FU_ISSUE_SCHEDULER -- requirements
Module: fu_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_FU, default 6: number of functional units, IDs 0..NUM_FU-1.
REQ-002 SHALL have parameter MAX_FU_LATENCY, default 31: largest legal issue latency.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port issue_valid, input, 1 bit: decode presents an instruction.
REQ-006 SHALL have port issue_fu, input, 3 bits: target FU ID.
REQ-007 SHALL have port issue_lat, input, 5 bits: FU latency L, in cycles.
REQ-008 SHALL have port issue_rd, input, 5 bits: destination register; 0 means no write.
REQ-009 SHALL have port issue_rs1, input, 5 bits: source register 1; 0 means unused.
REQ-010 SHALL have port issue_rs2, input, 5 bits: source register 2; 0 means unused.
REQ-011 SHALL have port issue_ready, output, 1 bit: combinational acceptance.
REQ-012 SHALL have port flush, input, 1 bit: synchronous clear of all in-flight state.
REQ-013 SHALL have port fu_status, output, NUM_FU bits: FU busy flags.
REQ-014 SHALL have port fu_write_to, output, NUM_FU*5 bits: flattened destination register per FU.
REQ-015 SHALL have port fu_writeback_en, output, NUM_FU bits: one-hot writeback strobe.
REQ-016 SHALL have port wb_rd, output, 5 bits: register written back this cycle; 0 if none.
REQ-017 SHALL have port err_lat, output, 1 bit: sticky flag for an illegal latency.

Function
REQ-018 SHALL hold a reservation table reservation[0..MAX_FU_LATENCY]; each entry is 0 (empty) or FU ID+1; slot k means "writes back k cycles from now".
REQ-019 SHALL shift the table every cycle: reservation[k] <= reservation[k+1], and the top slot <= 0.
REQ-020 SHALL define accept = issue_valid & issue_ready.
REQ-021 SHALL, on accept, additionally write reservation[L-1] <= issue_fu+1, set fu_status[issue_fu], and set fu_write_to[issue_fu] <= issue_rd.
REQ-022 SHALL give latency accept@t -> fu_writeback_en[issue_fu] high in exactly cycle t+L, for one cycle.
REQ-023 SHALL, when reservation[0] = f+1, assert fu_writeback_en[f], drive wb_rd = fu_write_to[f], and clear fu_status[f] at the next edge.
REQ-024 SHALL deassert issue_ready if fu_status[issue_fu] = 1; the FU stays busy in its own writeback cycle.
REQ-025 SHALL deassert issue_ready on a writeback-port conflict, i.e. reservation[L] != 0.
REQ-026 SHALL deassert issue_ready on RAW: a nonzero rs1/rs2 equals fu_write_to[f] of any busy f. There is no bypass; this includes f writing back this cycle.
REQ-027 SHALL deassert issue_ready on WAW: a nonzero issue_rd equals fu_write_to[f] of any busy f.
REQ-028 SHALL, for L = 0, L > MAX_FU_LATENCY or issue_fu >= NUM_FU, deassert issue_ready and set err_lat; err_lat clears only on rst.
REQ-029 SHALL, on flush, clear the table, fu_status and fu_write_to, and suppress any accept in that cycle. fu_writeback_en still reflects the pre-flush reservation[0].
REQ-030 SHALL treat issue_ready as independent of issue_valid, apart from the operand decode.

Reset
REQ-031 SHALL on rst asynchronously clear the table, fu_status, fu_write_to and err_lat, and force fu_writeback_en = 0 and wb_rd = 0.
REQ-032 SHALL, on rst mid-operation, discard pending writebacks; no strobe fires for them after rst falls.

Structure
REQ-033 SHALL take NUM_FU, MAX_FU_LATENCY, the FU ID width and FU ID constants (ALU, MEM, MUL, DIV, FPU, JUMP) from shared package rv32_fu_pkg.
REQ-034 SHALL place the shift table in a sub-module fu_reservation_shifter, with ports: shift, write enable, write index, write value, slot-0 value, and a lookup at index L.
REQ-035 SHALL expose reservation_reg, FU_status, FU_write_to and FU_writeback_en as internal signals under those hierarchical names, for core-level probing.

Verification
REQ-036 SHALL test single issue: fu=2, L=4, rd=5 accepted @t -> fu_writeback_en=6'b000100 and wb_rd=5 @t+4 -> fu_status[2]=0 @t+5.
REQ-037 SHALL test port conflict: fu=1, L=3 @t, then fu=3, L=2 @t+1 -> second stalled @t+1, accepted @t+2.
REQ-038 SHALL test RAW: fu=0, L=5, rd=7 @t, then rs1=7 -> issue_ready=0 through t+5, 1 @t+6.
REQ-039 SHALL test WAW plus busy FU: rd=9 on fu=4 pending, new rd=9 or fu=4 -> stalled until fu 4 retires.
REQ-040 SHALL test illegal latency: L=0 -> issue_ready=0 and err_lat=1, held until rst.
REQ-041 SHALL test rst and flush mid-flight: 3 ops pending, assert rst -> all outputs 0 immediately and no later strobes; repeat with flush -> same state the next cycle.
